pipeline_exec_ctrl: RTL and testbench
=====================================

Name: pipeline_exec_ctrl

Overview:
Run/step/halt sequencer for the 5-stage MIPS pipeline. Starts execution when commanded by the debug unit, runs either continuously or one clock per step pulse, and generates the PC, IF/ID and ID/EX enable/flush/bubble controls from the ID-stage hazard flag. On fetching the HALT instruction it freezes fetch, drains the in-flight instructions and reports completion with an executed-cycle count.

Parameters:
HALT_INSTR, 32'hFC000000, instruction word that ends a program
DRAIN_CYCLES, 4, enabled non-stalled cycles needed after HALT fetch to retire everything ahead of it (1..15)
CNT_W, 32, width of cycle counter

Ports:
i_clk  in  1  clock; all state on rising edge
i_rst  in  1  asynchronous reset, active-low (0 = reset)
i_start  in  1  one-cycle pulse: begin run; honoured only in IDLE or DONE
i_mode  in  1  0 = continuous, 1 = step; sampled only with accepted i_start
i_step  in  1  one-cycle pulse: execute one clock; honoured only in STEP_WAIT
i_abort  in  1  return to IDLE next edge, from any state
i_hazard_detected  in  1  load-use stall request from ID stage
i_if_instruction  in  32  word being fetched this cycle
o_pipe_en  out  1  global enable for EX/MEM/WB pipeline registers
o_pc_en  out  1  PC register write enable
o_if_id_en  out  1  IF/ID register write enable
o_if_flush  out  1  IF/ID loads NOP instead of fetched word
o_id_ex_bubble  out  1  ID/EX loads zero control (bubble)
o_busy  out  1  high in RUN, STEP_WAIT, STEP_EXEC
o_done  out  1  high in DONE
o_cycle_cnt  out  CNT_W  enabled cycles executed in current run
o_state  out  3  encoded state for debug readout

Behaviour:
- States/encoding: IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DONE=4. Other codes -> IDLE.
- Reset (i_rst=0, async): state IDLE, halt_seen=0, drain_cnt=0, o_cycle_cnt=0; all outputs 0.
- Priority per edge: i_abort > normal transitions. Abort clears halt_seen/drain_cnt, keeps o_cycle_cnt.
- IDLE/DONE + i_start: o_cycle_cnt<=0, halt_seen<=0, next = RUN (i_mode=0) or STEP_WAIT (i_mode=1). i_step ignored.
- RUN: stays until DONE condition or abort. i_start, i_step ignored.
- STEP_WAIT: i_step -> STEP_EXEC; else hold. No enables.
- STEP_EXEC: exactly one cycle; -> STEP_WAIT, or DONE if DONE condition met this cycle.
- Combinational outputs (Moore on state plus hazard):
  en = (state==RUN || state==STEP_EXEC)
  o_pipe_en = en
  o_pc_en = en & ~i_hazard_detected & ~halt_seen
  o_if_id_en = en & ~i_hazard_detected
  o_if_flush = en & ~i_hazard_detected & halt_seen
  o_id_ex_bubble = en & i_hazard_detected
- Cycle count: o_cycle_cnt += 1 on every edge with en=1 (stalled cycles included); saturates at all-ones.
- Accepted cycle: en & ~i_hazard_detected.
- HALT detect: accepted cycle, halt_seen=0, i_if_instruction==HALT_INSTR -> halt_seen<=1, drain_cnt<=DRAIN_CYCLES. The HALT word itself is loaded into IF/ID.
- Drain: each accepted cycle with halt_seen=1 decrements drain_cnt; the decrement from 1 to 0 is the DONE condition -> state DONE on that edge. Stalled cycles do not decrement.
- DONE: all enables 0, o_done=1, count frozen until next i_start.
- Latency: i_start edge -> en=1 in next cycle (RUN); i_step edge -> exactly one en cycle.

Test Plan:
- Continuous run, DRAIN_CYCLES=4, HALT presented on 6th enabled cycle, no hazards -> o_pc_en drops from 7th cycle, o_if_flush=1 cycles 7-10, state DONE after 10th, o_cycle_cnt=10, o_done=1.
- Step mode, 3 i_step pulses spaced 5 cycles -> exactly 3 single-cycle o_pipe_en pulses, o_cycle_cnt=3, state back to 2 after each, i_start during steps ignored.
- RUN with i_hazard_detected high 2 cycles -> o_pc_en=0, o_if_id_en=0, o_id_ex_bubble=1 for those 2 cycles, o_pipe_en=1, count +2.
- HALT fetched then hazard during drain (1 cycle) -> DONE one cycle later than no-hazard case, o_cycle_cnt=11.
- i_abort in RUN at count 7 -> IDLE next edge, all enables 0, o_cycle_cnt holds 7; new i_start clears to 0.
- i_rst low mid-RUN (asynchronous, between edges) -> outputs 0 immediately, state 0, count 0; HALT on same edge as reset release is ignored.

Source files
------------

// File: rtl/pipeline_exec_ctrl_if.sv
// Debug-unit / hazard-unit side of the run/step/halt sequencer.
// The master drives the run commands, hazard flag and fetched word.
// The slave (the sequencer) returns the pipeline enables and status.
interface pipeline_exec_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             i_start;
   logic             i_mode;
   logic             i_step;
   logic             i_abort;
   logic             i_hazard_detected;
   logic [31:0]      i_if_instruction;
   logic             o_pipe_en;
   logic             o_pc_en;
   logic             o_if_id_en;
   logic             o_if_flush;
   logic             o_id_ex_bubble;
   logic             o_busy;
   logic             o_done;
   logic [CNT_W-1:0] o_cycle_cnt;
   logic [2:0]       o_state;

   modport master (
      output i_start, i_mode, i_step, i_abort, i_hazard_detected, i_if_instruction,
      input  o_pipe_en, o_pc_en, o_if_id_en, o_if_flush, o_id_ex_bubble,
             o_busy, o_done, o_cycle_cnt, o_state
   );

   modport slave (
      input  i_start, i_mode, i_step, i_abort, i_hazard_detected, i_if_instruction,
      output o_pipe_en, o_pc_en, o_if_id_en, o_if_flush, o_id_ex_bubble,
             o_busy, o_done, o_cycle_cnt, o_state
   );
endinterface

// File: rtl/pipeline_exec_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline.
// Runs continuously or one clock per step pulse, turns the ID-stage hazard
// flag into PC / IF-ID / ID-EX controls, and after fetching HALT freezes
// fetch, drains the in-flight instructions and reports DONE with a count
// of enabled cycles. CNT_W must match the width the interface was built with.
module pipeline_exec_ctrl #(
   parameter logic [31:0] HALT_INSTR   = 32'hFC000000,
   parameter int          DRAIN_CYCLES = 4,
   parameter int          CNT_W        = 32
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   pipeline_exec_ctrl_if.slave     bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RUN       = 3'd1,
      STEP_WAIT = 3'd2,
      STEP_EXEC = 3'd3,
      DONE      = 3'd4
   } state_t;

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

   state_t           state_reg, state_next;
   logic             halt_seen_reg, halt_seen_next;
   logic [3:0]       drain_cnt_reg, drain_cnt_next;
   logic [CNT_W-1:0] cycle_cnt_reg, cycle_cnt_next;

   logic en;
   logic accepted;

   assign en       = (state_reg == RUN) || (state_reg == STEP_EXEC);
   assign accepted = en & ~bus.i_hazard_detected;

   // State, halt tracking and cycle counter registers
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_reg     <= IDLE;
         halt_seen_reg <= 1'b0;
         drain_cnt_reg <= 4'd0;
         cycle_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         halt_seen_reg <= halt_seen_next;
         drain_cnt_reg <= drain_cnt_next;
         cycle_cnt_reg <= cycle_cnt_next;
      end
   end

   // Next-state logic: abort wins, then start/step/halt/drain handling
   always_comb begin
      state_next     = state_reg;
      halt_seen_next = halt_seen_reg;
      drain_cnt_next = drain_cnt_reg;
      cycle_cnt_next = cycle_cnt_reg;

      if (bus.i_abort) begin
         // Count is kept so the debugger can still read how far the run got
         state_next     = IDLE;
         halt_seen_next = 1'b0;
         drain_cnt_next = 4'd0;
      end else begin
         // Stalled cycles count too; saturate instead of wrapping
         if (en && (cycle_cnt_reg != {CNT_W{1'b1}}))
            cycle_cnt_next = cycle_cnt_reg + CNT_W'(1);

         case (state_reg)
            IDLE, DONE: begin
               if (bus.i_start) begin
                  cycle_cnt_next = '0;
                  halt_seen_next = 1'b0;
                  drain_cnt_next = 4'd0;
                  state_next     = bus.i_mode ? STEP_WAIT : RUN;
               end
            end
            RUN, STEP_EXEC: begin
               if (state_reg == STEP_EXEC)
                  state_next = STEP_WAIT;
               if (accepted) begin
                  if (halt_seen_reg) begin
                     // Only non-stalled cycles move older instructions forward
                     drain_cnt_next = drain_cnt_reg - 4'd1;
                     if (drain_cnt_reg == 4'd1)
                        state_next = DONE;
                  end else if (bus.i_if_instruction == HALT_INSTR) begin
                     // HALT itself goes into IF/ID; fetch is frozen from here on
                     halt_seen_next = 1'b1;
                     drain_cnt_next = DRAIN_LOAD;
                  end
               end
            end
            STEP_WAIT: begin
               if (bus.i_step)
                  state_next = STEP_EXEC;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Pipeline controls depend on state plus the live hazard flag
   always_comb begin
      bus.o_pipe_en      = en;
      bus.o_pc_en        = en & ~bus.i_hazard_detected & ~halt_seen_reg;
      bus.o_if_id_en     = en & ~bus.i_hazard_detected;
      bus.o_if_flush     = en & ~bus.i_hazard_detected & halt_seen_reg;
      bus.o_id_ex_bubble = en & bus.i_hazard_detected;
      bus.o_busy         = (state_reg == RUN) || (state_reg == STEP_WAIT) ||
                           (state_reg == STEP_EXEC);
      bus.o_done         = (state_reg == DONE);
      bus.o_cycle_cnt    = cycle_cnt_reg;
      bus.o_state        = state_reg;
   end

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Testbench for pipeline_exec_ctrl: a table-driven continuous run to HALT,
// hand-written step/hazard/abort/reset/saturation sequences, then random
// stimulus compared cycle by cycle with a behavioural model.
module tb_pipeline_exec_ctrl;

   localparam logic [31:0] HALT  = 32'hFC000000;
   localparam int          DRAIN = 4;
   localparam int          CW    = 4;
   localparam int          CMAX  = (1 << CW) - 1;

   logic clk;
   logic rst_n;

   pipeline_exec_ctrl_if #(.CNT_W(CW)) bus ();

   pipeline_exec_ctrl #(
      .HALT_INSTR(HALT),
      .DRAIN_CYCLES(DRAIN),
      .CNT_W(CW)
   ) dut (
      .i_clk(clk),
      .i_rst(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Sampled DUT values and model expectations for the current cycle
   logic [6:0] act_outs;
   logic [3:0] act_cnt;
   logic [2:0] act_state;
   logic [6:0] exp_outs;
   int         exp_cnt;
   int         exp_state;

   // Behavioural model: run phase, halt flag, instructions left to retire, count
   int m_st;
   bit m_halt;
   int m_left;
   int m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_st = 0; m_halt = 0; m_left = 0; m_cnt = 0;
   endfunction

   function automatic void model_out(input logic hz);
      bit run_cycle;
      run_cycle = (m_st == 1) || (m_st == 3);
      exp_outs  = {run_cycle, run_cycle && !hz && !m_halt, run_cycle && !hz,
                   run_cycle && !hz && m_halt, run_cycle && hz,
                   (m_st >= 1 && m_st <= 3), m_st == 4};
      exp_state = m_st;
      exp_cnt   = m_cnt;
   endfunction

   function automatic void model_step(input logic st, input logic md, input logic sp,
                                      input logic ab, input logic hz, input logic [31:0] ins);
      bit run_cycle, finished;
      run_cycle = (m_st == 1) || (m_st == 3);
      finished  = 0;
      if (ab) begin
         m_st = 0; m_halt = 0; m_left = 0;
         return;
      end
      if (run_cycle && m_cnt < CMAX) m_cnt++;
      if (m_st == 0 || m_st == 4) begin
         if (st) begin
            m_cnt = 0; m_halt = 0;
            m_st = md ? 2 : 1;
         end
      end else if (m_st == 2) begin
         if (sp) m_st = 3;
      end else if (run_cycle) begin
         if (!hz) begin
            if (m_halt) begin
               m_left--;
               finished = (m_left == 0);
            end else if (ins == HALT) begin
               m_halt = 1;
               m_left = DRAIN;
            end
         end
         if (finished)       m_st = 4;
         else if (m_st == 3) m_st = 2;
      end else begin
         m_st = 0;
      end
   endfunction

   // One clock: drive inputs after the falling edge, sample, advance the model
   task automatic tick(input logic st, input logic md, input logic sp,
                       input logic ab, input logic hz, input logic [31:0] ins);
      @(negedge clk);
      bus.i_start = st; bus.i_mode = md; bus.i_step = sp;
      bus.i_abort = ab; bus.i_hazard_detected = hz; bus.i_if_instruction = ins;
      #1;
      act_outs  = {bus.o_pipe_en, bus.o_pc_en, bus.o_if_id_en, bus.o_if_flush,
                   bus.o_id_ex_bubble, bus.o_busy, bus.o_done};
      act_cnt   = bus.o_cycle_cnt;
      act_state = bus.o_state;
      model_out(hz);
      model_step(st, md, sp, ab, hz, ins);
      @(posedge clk);
   endtask

   typedef struct {
      logic        start, mode, step, abort, hazard;
      logic [31:0] instr;
      logic [2:0]  e_state;
      logic [6:0]  e_outs;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t tbl[13];
   int   pulses;

   initial begin
      rst_n = 1'b0;
      bus.i_start = 0; bus.i_mode = 0; bus.i_step = 0; bus.i_abort = 0;
      bus.i_hazard_detected = 0; bus.i_if_instruction = 32'h0;
      model_reset();

      // Continuous run, HALT on 6th enabled cycle, no hazards
      tbl[0] = '{1, 0, 0, 0, 0, 32'h0, 3'd0, 7'b0000000, 4'd0};
      for (int k = 1; k <= 10; k++) begin
         tbl[k] = '{0, 0, 0, 0, 0, (k == 6) ? HALT : 32'h2000_0000 + k, 3'd1,
                    {1'b1, (k <= 6), 1'b1, (k >= 7), 1'b0, 1'b1, 1'b0}, 4'(k - 1)};
      end
      tbl[11] = '{0, 0, 0, 0, 0, 32'h0, 3'd4, 7'b0000001, 4'd10};
      tbl[12] = '{0, 0, 1, 0, 0, HALT,  3'd4, 7'b0000001, 4'd10};

      // Reset state while reset is held
      #7;
      chk("reset_outs",  32'({bus.o_pipe_en, bus.o_pc_en, bus.o_if_id_en, bus.o_if_flush,
                              bus.o_id_ex_bubble, bus.o_busy, bus.o_done}), 32'd0);
      chk("reset_state", 32'(bus.o_state), 32'd0);
      chk("reset_cnt",   32'(bus.o_cycle_cnt), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         tick(tbl[i].start, tbl[i].mode, tbl[i].step, tbl[i].abort, tbl[i].hazard, tbl[i].instr);
         $display("vec %0d: state=%0d outs=%b cnt=%0d", i, act_state, act_outs, act_cnt);
         chk($sformatf("vec%0d_state", i), 32'(act_state), 32'(tbl[i].e_state));
         chk($sformatf("vec%0d_outs", i),  32'(act_outs),  32'(tbl[i].e_outs));
         chk($sformatf("vec%0d_cnt", i),   32'(act_cnt),   32'(tbl[i].e_cnt));
      end

      // Step mode: three spaced steps, start during steps ignored
      tick(1, 1, 0, 0, 0, 32'h0);
      pulses = 0;
      for (int s = 0; s < 3; s++) begin
         tick(0, 0, 1, 0, 0, 32'h1);
         chk("step_wait_state", 32'(act_state), 32'd2);
         for (int j = 0; j < 5; j++) begin
            tick((j == 2), 0, 0, 0, 0, 32'h1);
            if (j == 0) chk("step_exec_state", 32'(act_state), 32'd3);
            pulses += int'(act_outs[6]);
         end
         $display("step %0d: pulses so far=%0d", s, pulses);
      end
      tick(0, 0, 0, 0, 0, 32'h0);
      chk("step_pulses", 32'(pulses), 32'd3);
      chk("step_cnt",    32'(act_cnt), 32'd3);
      chk("step_state",  32'(act_state), 32'd2);

      // Hazard for two cycles in RUN
      tick(0, 0, 0, 1, 0, 32'h0);
      tick(1, 0, 0, 0, 0, 32'h0);
      for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0, 32'h3);
      for (int k = 0; k < 2; k++) begin
         tick(0, 0, 0, 0, 1, 32'h3);
         $display("hazard cycle %0d: outs=%b cnt=%0d", k, act_outs, act_cnt);
         chk("hazard_outs", 32'(act_outs), 32'b1000110);
         chk("hazard_cnt",  32'(act_cnt), 32'(3 + k));
      end
      tick(0, 0, 0, 0, 0, 32'h3);
      chk("post_hazard_outs", 32'(act_outs), 32'b1110010);
      chk("post_hazard_cnt",  32'(act_cnt), 32'd5);

      // Abort in RUN at count 7
      tick(0, 0, 0, 0, 0, 32'h3);
      tick(0, 0, 0, 1, 0, 32'h3);
      chk("abort_pre_cnt", 32'(act_cnt), 32'd7);
      tick(0, 0, 0, 0, 0, 32'h3);
      $display("after abort: state=%0d outs=%b cnt=%0d", act_state, act_outs, act_cnt);
      chk("abort_state", 32'(act_state), 32'd0);
      chk("abort_outs",  32'(act_outs), 32'd0);
      chk("abort_cnt",   32'(act_cnt), 32'd7);
      tick(1, 0, 0, 0, 0, 32'h0);
      tick(0, 0, 0, 0, 0, 32'h0);
      chk("restart_cnt",   32'(act_cnt), 32'd0);
      chk("restart_state", 32'(act_state), 32'd1);

      // HALT then one stalled drain cycle
      tick(0, 0, 0, 1, 0, 32'h0);
      tick(1, 0, 0, 0, 0, 32'h0);
      for (int k = 1; k <= 11; k++) begin
         tick(0, 0, 0, 0, (k == 7), (k == 6) ? HALT : 32'h4);
         if (k == 11) chk("halt_hz_last_state", 32'(act_state), 32'd1);
      end
      tick(0, 0, 0, 0, 0, 32'h0);
      $display("halt+hazard: state=%0d cnt=%0d", act_state, act_cnt);
      chk("halt_hz_state", 32'(act_state), 32'd4);
      chk("halt_hz_cnt",   32'(act_cnt), 32'd11);

      // Counter saturation
      tick(1, 0, 0, 0, 0, 32'h0);
      for (int k = 0; k < 20; k++) tick(0, 0, 0, 0, 0, 32'h5);
      chk("sat_cnt", 32'(act_cnt), 32'(CMAX));

      // Asynchronous reset between edges mid-run
      tick(0, 0, 0, 1, 0, 32'h0);
      tick(1, 0, 0, 0, 0, 32'h0);
      for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0, 32'h6);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      $display("async reset: state=%0d cnt=%0d", bus.o_state, bus.o_cycle_cnt);
      chk("areset_outs", 32'({bus.o_pipe_en, bus.o_pc_en, bus.o_if_id_en, bus.o_if_flush,
                              bus.o_id_ex_bubble, bus.o_busy, bus.o_done}), 32'd0);
      chk("areset_state", 32'(bus.o_state), 32'd0);
      chk("areset_cnt",   32'(bus.o_cycle_cnt), 32'd0);
      bus.i_if_instruction = HALT;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      tick(0, 0, 0, 0, 0, HALT);
      chk("post_reset_state", 32'(act_state), 32'd0);
      chk("post_reset_cnt",   32'(act_cnt), 32'd0);

      // Random stimulus against the model
      for (int n = 0; n < 400; n++) begin
         logic r_st, r_md, r_sp, r_ab, r_hz;
         logic [31:0] r_in;
         r_st = ($urandom_range(0, 11) == 0);
         r_md = $urandom_range(0, 1);
         r_sp = ($urandom_range(0, 2) == 0);
         r_ab = ($urandom_range(0, 63) == 0);
         r_hz = ($urandom_range(0, 3) == 0);
         r_in = ($urandom_range(0, 5) == 0) ? HALT : $urandom();
         tick(r_st, r_md, r_sp, r_ab, r_hz, r_in);
         $display("rnd %0d: in=%b%b%b%b%b state=%0d/%0d outs=%b/%b cnt=%0d/%0d", n,
                  r_st, r_md, r_sp, r_ab, r_hz, act_state, exp_state,
                  act_outs, exp_outs, act_cnt, exp_cnt);
         chk("rnd_state", 32'(act_state), 32'(exp_state));
         chk("rnd_outs",  32'(act_outs),  32'(exp_outs));
         chk("rnd_cnt",   32'(act_cnt),   32'(exp_cnt));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
